// File: rtl/uart_shift_reg.sv
// Shift register with frame-length counter for the UART datapath.
// Serves as TX serialiser (parallel load) or RX deserialiser (shift in) under a bit-rate strobe.
module uart_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1,
   parameter logic        IDLE_VAL  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       start,
   input  logic                       load_par,
   input  logic [WIDTH-1:0]           par_in,
   input  logic                       shift_en,
   input  logic                       ser_in,
   output logic [WIDTH-1:0]           par_out,
   output logic                       ser_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    count_q, count_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   // Priority: clr > start > shift_en; start while busy restarts the frame without done.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      done_d  = 1'b0;
      if (clr) begin
         state_d = StIdle;
         data_d  = '0;
         count_d = '0;
      end else if (start) begin
         state_d = StShift;
         count_d = CW'(WIDTH);
         if (load_par) begin
            data_d = par_in;
         end
      end else if (state_q == StShift && shift_en) begin
         if (LSB_FIRST) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
         end else begin
            data_d = {data_q[WIDTH-2:0], ser_in};
         end
         count_d = count_q - CW'(1);
         if (count_q == CW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
      end
   end

   assign busy    = (state_q == StShift);
   assign done    = done_q;
   assign count   = count_q;
   assign par_out = data_q;
   assign ser_out = busy ? (LSB_FIRST ? data_q[0] : data_q[WIDTH-1]) : IDLE_VAL;

endmodule

// File: tb/tb_uart_shift_reg.sv
// Directed bench for uart_shift_reg: one LSB-first and one MSB-first instance on shared stimulus.
module tb_uart_shift_reg;

   logic       clk = 1'b0;
   logic       rst, clr, start, load_par, shift_en, ser_in;
   logic [7:0] par_in;
   logic [7:0] par_out_l, par_out_m;
   logic       ser_out_l, ser_out_m, busy_l, busy_m, done_l, done_m;
   logic [3:0] count_l, count_m;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_l (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .load_par(load_par), .par_in(par_in),
      .shift_en(shift_en), .ser_in(ser_in), .par_out(par_out_l), .ser_out(ser_out_l),
      .busy(busy_l), .done(done_l), .count(count_l)
   );

   uart_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_m (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .load_par(load_par), .par_in(par_in),
      .shift_en(shift_en), .ser_in(ser_in), .par_out(par_out_m), .ser_out(ser_out_m),
      .busy(busy_m), .done(done_m), .count(count_m)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr = 0; start = 0; load_par = 0; shift_en = 0; ser_in = 0; par_in = 8'h00;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #3;
      checks++;
      if ({par_out_l, count_l, busy_l, done_l, ser_out_l} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_state: got par=%h cnt=%0d busy=%b done=%b ser=%b",
                  par_out_l, count_l, busy_l, done_l, ser_out_l);
         failures++;
      end
      tick();
      rst = 1;
      tick();
      // Frame in flight, then async reset mid-frame.
      start = 1; load_par = 1; par_in = 8'hFF;
      tick();
      start = 0; load_par = 0; shift_en = 1;
      for (int i = 0; i < 3; i++) tick();
      shift_en = 0;
      checks++;
      if ({par_out_l, count_l, busy_l} !== {8'h1F, 4'd5, 1'b1}) begin
         $display("FAIL reset_preframe: got par=%h cnt=%0d busy=%b need 1f 5 1",
                  par_out_l, count_l, busy_l);
         failures++;
      end
      #2 rst = 0;
      #1;
      checks++;
      if ({par_out_l, count_l, busy_l, done_l, ser_out_l} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_midframe: got par=%h cnt=%0d busy=%b done=%b ser=%b",
                  par_out_l, count_l, busy_l, done_l, ser_out_l);
         failures++;
      end
      shift_en = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done_l !== 1'b0 || count_l !== 4'd0) begin
            $display("FAIL reset_hold: got done=%b cnt=%0d need 0 0", done_l, count_l);
            failures++;
         end
      end
      shift_en = 0;
      rst = 1;
      tick();
      checks++;
      if (done_l !== 1'b0 || busy_l !== 1'b0) begin
         $display("FAIL reset_release: got done=%b busy=%b need 0 0", done_l, busy_l);
         failures++;
      end
   endtask

   task automatic test_tx_lsb();
      logic [7:0] exp_bits;
      exp_bits = 8'b1010_0101;
      start = 1; load_par = 1; par_in = 8'hA5;
      tick();
      start = 0; load_par = 0; shift_en = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ser_out_l !== exp_bits[i] || count_l !== 4'(8 - i) || done_l !== 1'b0) begin
            $display("FAIL tx_lsb_bit%0d: got ser=%b cnt=%0d done=%b need ser=%b cnt=%0d done=0",
                     i, ser_out_l, count_l, done_l, exp_bits[i], 8 - i);
            failures++;
         end
         tick();
      end
      shift_en = 0;
      checks++;
      if ({busy_l, done_l, ser_out_l, count_l} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
         $display("FAIL tx_lsb_end: got busy=%b done=%b ser=%b cnt=%0d need 0 1 1 0",
                  busy_l, done_l, ser_out_l, count_l);
         failures++;
      end
      tick();
      checks++;
      if (done_l !== 1'b0) begin
         $display("FAIL tx_lsb_done_width: got done=%b need 0", done_l);
         failures++;
      end
   endtask

   task automatic test_rx_lsb();
      logic [7:0] pat;
      pat = 8'h3C;
      start = 1; load_par = 0;
      tick();
      start = 0; shift_en = 1;
      for (int i = 0; i < 8; i++) begin
         ser_in = pat[i];
         checks++;
         if (count_l !== 4'(8 - i)) begin
            $display("FAIL rx_lsb_count%0d: got %0d need %0d", i, count_l, 8 - i);
            failures++;
         end
         tick();
      end
      shift_en = 0; ser_in = 0;
      checks++;
      if ({par_out_l, done_l, count_l} !== {8'h3C, 1'b1, 4'd0}) begin
         $display("FAIL rx_lsb_result: got par=%h done=%b cnt=%0d need 3c 1 0",
                  par_out_l, done_l, count_l);
         failures++;
      end
      tick();
   endtask

   task automatic test_gapped();
      start = 1; load_par = 1; par_in = 8'h5A;
      tick();
      start = 0; load_par = 0; ser_in = 1;
      for (int i = 0; i < 8; i++) begin
         shift_en = 1;
         tick();
         shift_en = 0;
         for (int g = 0; g < 2; g++) begin
            checks++;
            if (done_l !== ((i == 7 && g == 0) ? 1'b1 : 1'b0) || count_l !== 4'(7 - i)) begin
               $display("FAIL gap_s%0d_g%0d: got done=%b cnt=%0d need done=%b cnt=%0d",
                        i, g, done_l, count_l, (i == 7 && g == 0), 7 - i);
               failures++;
            end
            tick();
         end
      end
      checks++;
      if (par_out_l !== 8'hFF) begin
         $display("FAIL gap_result: got %h need ff", par_out_l);
         failures++;
      end
      ser_in = 0; shift_en = 1;
      tick();
      tick();
      shift_en = 0;
      checks++;
      if ({par_out_l, count_l, done_l, busy_l} !== {8'hFF, 4'd0, 1'b0, 1'b0}) begin
         $display("FAIL gap_post_done: got par=%h cnt=%0d done=%b busy=%b need ff 0 0 0",
                  par_out_l, count_l, done_l, busy_l);
         failures++;
      end
   endtask

   task automatic test_abort_priority();
      start = 1; load_par = 1; par_in = 8'h33;
      tick();
      start = 0; load_par = 0; shift_en = 1;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (count_l !== 4'd3) begin
         $display("FAIL abort_pre: got cnt=%0d need 3", count_l);
         failures++;
      end
      start = 1; load_par = 1; par_in = 8'h0F;
      tick();
      checks++;
      if ({count_l, par_out_l, done_l, busy_l, ser_out_l} !== {4'd8, 8'h0F, 1'b0, 1'b1, 1'b1}) begin
         $display("FAIL abort_restart: got cnt=%0d par=%h done=%b busy=%b ser=%b need 8 0f 0 1 1",
                  count_l, par_out_l, done_l, busy_l, ser_out_l);
         failures++;
      end
      clr = 1; start = 1; shift_en = 0;
      tick();
      clr = 0; start = 0; load_par = 0;
      checks++;
      if ({par_out_l, busy_l, count_l, done_l, ser_out_l} !== {8'h00, 1'b0, 4'd0, 1'b0, 1'b1}) begin
         $display("FAIL clr_start: got par=%h busy=%b cnt=%0d done=%b ser=%b need 00 0 0 0 1",
                  par_out_l, busy_l, count_l, done_l, ser_out_l);
         failures++;
      end
      tick();
      checks++;
      if (done_l !== 1'b0) begin
         $display("FAIL clr_no_done: got done=%b need 0", done_l);
         failures++;
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] pat;
      pat = 8'hC0;
      start = 1; load_par = 1; par_in = 8'hC0;
      tick();
      start = 0; load_par = 0; shift_en = 1; ser_in = 0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ser_out_m !== pat[7 - i]) begin
            $display("FAIL msb_tx_bit%0d: got %b need %b", i, ser_out_m, pat[7 - i]);
            failures++;
         end
         tick();
      end
      shift_en = 0;
      checks++;
      if ({done_m, busy_m, ser_out_m} !== {1'b1, 1'b0, 1'b1}) begin
         $display("FAIL msb_tx_end: got done=%b busy=%b ser=%b need 1 0 1",
                  done_m, busy_m, ser_out_m);
         failures++;
      end
      pat = 8'h81;
      start = 1; load_par = 0;
      tick();
      start = 0; shift_en = 1;
      for (int i = 0; i < 8; i++) begin
         ser_in = pat[7 - i];
         tick();
      end
      shift_en = 0; ser_in = 0;
      checks++;
      if ({par_out_m, done_m, count_m} !== {8'h81, 1'b1, 4'd0}) begin
         $display("FAIL msb_rx_result: got par=%h done=%b cnt=%0d need 81 1 0",
                  par_out_m, done_m, count_m);
         failures++;
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_tx_lsb();
      test_rx_lsb();
      test_gapped();
      test_abort_priority();
      test_msb_first();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_shift_reg.md
Name: uart_shift_reg

Overview:
Parametrised shift register with a bit counter, for the UART datapath. One instance serves as TX serialiser (parallel load, shift out) or RX deserialiser (shift in, parallel read). A frame-length counter produces busy and a one-cycle done pulse. Shifting is paced by an external bit-rate strobe on shift_en.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..32
LSB_FIRST, 1, 1 = shift toward bit 0 (LSB leaves/arrives first); 0 = MSB first
IDLE_VAL, 1'b1, value driven on ser_out while not busy (UART line idle level)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
clr  in  1  synchronous clear, highest priority after rst
start  in  1  begin a frame; one-cycle pulse
load_par  in  1  sampled with start: 1 = load par_in (TX); 0 = keep data (RX)
par_in  in  WIDTH  parallel load data
shift_en  in  1  bit strobe; one shift per cycle asserted while busy
ser_in  in  1  serial input, enters the vacated end
par_out  out  WIDTH  current register contents, always driven
ser_out  out  1  output-end bit while busy, IDLE_VAL otherwise
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final shift
count  out  $clog2(WIDTH+1)  shifts remaining in the frame

Behaviour:
- Reset (rst=0, async): data=0, count=0, busy=0, done=0, ser_out=IDLE_VAL. Takes effect immediately, including mid-frame. No done is produced.
- Two states:
  - IDLE (busy=0): shift_en is ignored and data holds.
  - SHIFT (busy=1).
- Priority each cycle: clr > start > shift_en.
- clr: data=0, count=0, go to IDLE, done=0. An in-flight frame is aborted silently.
- start, from any state:
  - count<=WIDTH and busy<=1 at the next edge.
  - If load_par=1, data<=par_in. Otherwise data holds.
  - A shift_en in the same cycle is ignored.
  - start while busy restarts the frame: count reloads and no done is issued for the aborted frame.
- Shifting in SHIFT with shift_en=1 and no start/clr:
  - LSB_FIRST=1: data<={ser_in, data[WIDTH-1:1]}.
  - LSB_FIRST=0: data<={data[WIDTH-2:0], ser_in}.
  - count decrements by 1.
- Frame end: the shift that takes count 1->0 also sets busy<=0 and done<=1 on the same edge. done is visible for exactly one cycle, then clears. par_out holds the completed frame until the next start, load or clr.
- done is registered. It is never asserted for a start-only or clr cycle.
- ser_out is combinational from registered state:
  - busy ? (LSB_FIRST ? data[0] : data[WIDTH-1]) : IDLE_VAL.
  - The first bit appears the cycle after start. Each later bit appears the cycle after its shift_en.
- Gaps in shift_en: count, data and ser_out hold. There is no timeout.
- count never underflows. shift_en at count=0 (IDLE) has no effect.
- Latency: start to done = WIDTH accepted shift_en strobes + 1 edge.

Test Plan:
1. Reset mid-frame: WIDTH=8; start load_par=1 par_in=8'hFF, 3 shifts, then rst low -> par_out=8'h00, count=0, busy=0, done=0, ser_out=1 immediately; done never pulses.
2. TX LSB-first: start load_par=1 par_in=8'hA5, shift_en every cycle -> ser_out = 1,0,1,0,0,1,0,1; after 8th shift busy=0, done=1 for one cycle, ser_out=1.
3. RX LSB-first: start load_par=0; drive ser_in with bits of 8'h3C LSB first, one per shift_en -> par_out=8'h3C in the done cycle; count steps 8..0.
4. Gapped strobe: shift_en every 3rd cycle, par_in=8'h5A -> count holds between strobes; done exactly once, 1 cycle after the 8th strobe; shift_en after done has no effect on par_out.
5. Abort/priority: at count=3, assert start with load_par=1 par_in=8'h0F and shift_en together -> count=8, no shift, no done, ser_out=1 next cycle. Then clr with start together -> data=0, busy=0.
6. MSB-first: LSB_FIRST=0, par_in=8'hC0 -> ser_out = 1,1,0,0,0,0,0,0; RX of 8'h81 MSB first -> par_out=8'h81 at done.
